// File: rtl/mag_to_twos_if.sv
// Handshake bundle for the sign-magnitude to two's-complement converter:
// operand side (IN_*, MAG_IN, NEG_IN) and result side (OUT_*, TWOS_RESULT, OVF_FLAG).
interface mag_to_twos_if #(
  parameter int WIDTH = 6
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] MAG_IN;
  logic             NEG_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] TWOS_RESULT;
  logic             OVF_FLAG;

  // Converter side.
  modport slave (
    input  IN_VALID, MAG_IN, NEG_IN, OUT_READY,
    output IN_READY, OUT_VALID, TWOS_RESULT, OVF_FLAG
  );

  // Producer/consumer side.
  modport master (
    output IN_VALID, MAG_IN, NEG_IN, OUT_READY,
    input  IN_READY, OUT_VALID, TWOS_RESULT, OVF_FLAG
  );
endinterface

// File: rtl/mag_to_twos.sv
// Sign-magnitude to WIDTH-bit two's complement with saturation and a sticky overflow counter.
// One-cycle latency; result is held and IN_READY drops while OUT_READY=0 in FULL.
module mag_to_twos #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  mag_to_twos_if.slave        bus,
  input  logic                CNT_CLR,
  output logic [CNT_W-1:0]    OVF_COUNT
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [WIDTH-1:0] MAXP   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic [CNT_W-1:0] ovf_cnt_q;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] conv_res;
  logic             conv_ovf;

  assign in_ready = (state == EMPTY) | bus.OUT_READY;
  assign accept   = bus.IN_VALID & in_ready;

  // Negative magnitudes up to 2^(WIDTH-1) are representable; -0 folds to 0 via the +1 carry drop.
  always_comb begin
    conv_res = bus.MAG_IN;
    conv_ovf = 1'b0;
    if (!bus.NEG_IN) begin
      if (bus.MAG_IN > MAXP) begin
        conv_res = MAXP;
        conv_ovf = 1'b1;
      end
    end else begin
      if (bus.MAG_IN > MINNEG) begin
        conv_res = MINNEG;
        conv_ovf = 1'b1;
      end else begin
        conv_res = (~bus.MAG_IN) + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
            result_q    <= conv_res;
            ovf_q       <= conv_ovf;
          end
        end
        FULL: begin
          if (accept) begin
            result_q <= conv_res;
            ovf_q    <= conv_ovf;
          end else if (bus.OUT_READY) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Counts accepted overflows, independent of when the result drains.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_cnt_q <= '0;
    end else if (CNT_CLR) begin
      ovf_cnt_q <= '0;
    end else if (accept && conv_ovf && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_q <= ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.IN_READY    = in_ready;
  assign bus.OUT_VALID   = out_valid_q;
  assign bus.TWOS_RESULT = result_q;
  assign bus.OVF_FLAG    = ovf_q;
  assign OVF_COUNT       = ovf_cnt_q;
endmodule

// File: tb/tb_mag_to_twos.sv
// Directed bench for mag_to_twos: integer-arithmetic reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mag_to_twos;
  localparam int WIDTH = 6;
  localparam int CNT_W = 8;

  logic             CLK;
  logic             RST;
  logic             CNT_CLR;
  logic [CNT_W-1:0] OVF_COUNT;

  int checks   = 0;
  int failures = 0;

  mag_to_twos_if #(.WIDTH(WIDTH)) bus ();

  mag_to_twos #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .CNT_CLR   (CNT_CLR),
    .OVF_COUNT (OVF_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference conversion from signed integer value and clamping.
  function automatic void ref_conv(input logic n, input logic [WIDTH-1:0] m,
                                   output logic [WIDTH-1:0] r, output logic o);
    int v;
    int hi;
    int lo;
    hi = (1 << (WIDTH-1)) - 1;
    lo = -(1 << (WIDTH-1));
    v  = n ? -int'(m) : int'(m);
    o  = 1'b0;
    if (v > hi) begin v = hi; o = 1'b1; end
    if (v < lo) begin v = lo; o = 1'b1; end
    r = WIDTH'(v);
  endfunction

  // Model of the observable output state.
  logic             m_valid;
  logic [WIDTH-1:0] m_res;
  logic             m_ovf;
  int               m_cnt;

  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      m_valid = 1'b0;
      m_res   = '0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
    end else begin
      logic             m_ready;
      logic             acc;
      logic [WIDTH-1:0] r;
      logic             o;
      m_ready = !m_valid || bus.OUT_READY;
      check("mdl_out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
      check("mdl_in_ready", 32'(bus.IN_READY), 32'(m_ready));
      check("mdl_ovf_count", 32'(OVF_COUNT), 32'(m_cnt));
      if (m_valid) begin
        check("mdl_result", 32'(bus.TWOS_RESULT), 32'(m_res));
        check("mdl_ovf_flag", 32'(bus.OVF_FLAG), 32'(m_ovf));
      end
      acc = bus.IN_VALID && m_ready;
      ref_conv(bus.NEG_IN, bus.MAG_IN, r, o);
      if (acc) begin
        m_valid = 1'b1;
        m_res   = r;
        m_ovf   = o;
      end else if (m_valid && bus.OUT_READY) begin
        m_valid = 1'b0;
      end
      if (CNT_CLR) m_cnt = 0;
      else if (acc && o && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic n, input logic [WIDTH-1:0] m);
    int guard;
    guard = 0;
    bus.IN_VALID = 1'b1;
    bus.NEG_IN   = n;
    bus.MAG_IN   = m;
    @(negedge CLK);
    while (!bus.IN_READY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
    step();
    bus.IN_VALID = 1'b0;
  endtask

  task automatic peek(input string name, input logic [WIDTH-1:0] res, input logic ovf);
    @(negedge CLK);
    check({name, "_valid"}, 32'(bus.OUT_VALID), 32'd1);
    check({name, "_res"}, 32'(bus.TWOS_RESULT), 32'(res));
    check({name, "_ovf"}, 32'(bus.OVF_FLAG), 32'(ovf));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] r;
    logic             o;

    RST           = 1'b1;
    CNT_CLR       = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.MAG_IN    = '0;
    bus.NEG_IN    = 1'b0;
    bus.OUT_READY = 1'b1;

    // Pin the reference model to hand-computed values.
    ref_conv(1'b1, 6'd5, r, o);
    check("ref_neg5", 32'({r, o}), 32'(7'b111011_0));
    ref_conv(1'b1, 6'd32, r, o);
    check("ref_neg32", 32'({r, o}), 32'(7'b100000_0));
    ref_conv(1'b0, 6'd32, r, o);
    check("ref_pos32", 32'({r, o}), 32'(7'b011111_1));
    ref_conv(1'b1, 6'd0, r, o);
    check("ref_negzero", 32'({r, o}), 32'(7'b000000_0));

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_result", 32'(bus.TWOS_RESULT), 32'd0);
    check("rst_ovf", 32'(bus.OVF_FLAG), 32'd0);
    check("rst_count", 32'(OVF_COUNT), 32'd0);
    check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    step();

    // Single conversions.
    send(1'b0, 6'd5);  peek("pos5", 6'b000101, 1'b0);
    send(1'b1, 6'd5);  peek("neg5", 6'b111011, 1'b0);
    send(1'b1, 6'd32); peek("neg32", 6'b100000, 1'b0);

    // Boundaries.
    send(1'b0, 6'd31); peek("pos31", 6'b011111, 1'b0);
    send(1'b0, 6'd32); peek("pos32", 6'b011111, 1'b1);
    send(1'b1, 6'd33); peek("neg33", 6'b100000, 1'b1);
    send(1'b1, 6'd0);  peek("negzero", 6'b000000, 1'b0);
    @(negedge CLK);
    check("bnd_count", 32'(OVF_COUNT), 32'd2);
    step();

    // Backpressure: result held, second input stalled until drain.
    bus.OUT_READY = 1'b0;
    send(1'b1, 6'd3);
    bus.IN_VALID = 1'b1;
    bus.NEG_IN   = 1'b0;
    bus.MAG_IN   = 6'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_hold_valid", 32'(bus.OUT_VALID), 32'd1);
      check("bp_hold_res", 32'(bus.TWOS_RESULT), 32'(6'b111101));
      check("bp_hold_in_ready", 32'(bus.IN_READY), 32'd0);
      step();
    end
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_release_in_ready", 32'(bus.IN_READY), 32'd1);
    check("bp_release_res", 32'(bus.TWOS_RESULT), 32'(6'b111101));
    step();
    bus.IN_VALID = 1'b0;
    peek("bp_next", 6'b000111, 1'b0);

    // Streaming sweep, NEG starting at 1 for M=0 and alternating.
    for (int i = 0; i < 64; i++) begin
      bus.IN_VALID = 1'b1;
      bus.MAG_IN   = WIDTH'(i);
      bus.NEG_IN   = (i % 2 == 0);
      step();
    end
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("sweep_last_res", 32'(bus.TWOS_RESULT), 32'(6'b011111));
    check("sweep_count", 32'(OVF_COUNT), 32'd33);
    step();

    // Counter saturation and clear priority.
    for (int i = 0; i < 260; i++) begin
      bus.IN_VALID = 1'b1;
      bus.NEG_IN   = 1'b0;
      bus.MAG_IN   = 6'd63;
      step();
    end
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("sat_count", 32'(OVF_COUNT), 32'd255);
    step();
    bus.IN_VALID = 1'b1;
    CNT_CLR      = 1'b1;
    step();
    CNT_CLR = 1'b0;
    @(negedge CLK);
    check("clr_count", 32'(OVF_COUNT), 32'd0);
    step();
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("after_clr_count", 32'(OVF_COUNT), 32'd1);
    step();

    // Asynchronous reset while holding a result.
    bus.OUT_READY = 1'b0;
    send(1'b0, 6'd40);
    @(negedge CLK);
    check("pre_rst_valid", 32'(bus.OUT_VALID), 32'd1);
    check("pre_rst_ovf", 32'(bus.OVF_FLAG), 32'd1);
    check("pre_rst_count", 32'(OVF_COUNT), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    check("arst_valid", 32'(bus.OUT_VALID), 32'd0);
    check("arst_result", 32'(bus.TWOS_RESULT), 32'd0);
    check("arst_ovf", 32'(bus.OVF_FLAG), 32'd0);
    check("arst_count", 32'(OVF_COUNT), 32'd0);
    check("arst_in_ready", 32'(bus.IN_READY), 32'd1);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_valid", 32'(bus.OUT_VALID), 32'd0);
    check("post_rst_in_ready", 32'(bus.IN_READY), 32'd1);
    step();
    bus.OUT_READY = 1'b1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
